// File: rtl/motor_timer_ctrl.sv
// Fan/motor controller: four-speed FSM, preset countdown timer with a one-second
// prescaler, and a registered PWM drive whose duty tracks the speed at period boundaries.
module motor_timer_ctrl #(
  parameter int TICK_1S    = 100_000_000,
  parameter int PWM_PERIOD = 100,
  parameter int T_STEP_SEC = 60
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_speed,
  input  logic       i_btn_timer,
  input  logic       i_btn_stop,
  output logic [1:0] o_speed,
  output logic [1:0] o_timer_mode,
  output logic [8:0] o_remain_sec,
  output logic       o_pwm,
  output logic       o_running
);

  localparam int PSW = (TICK_1S > 1) ? $clog2(TICK_1S) : 1;
  localparam int PCW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

  typedef enum logic [1:0] {S_OFF, S_LOW, S_MID, S_HIGH} speed_e;

  speed_e           speed_q, speed_d;
  logic [1:0]       mode_q, mode_d;
  logic [8:0]       remain_q, remain_d;
  logic [PSW-1:0]   presc_q, presc_d;
  logic [PCW-1:0]   pwm_cnt_q, duty_q, duty_new, duty_eff;
  logic             pwm_q;
  logic             tick_wrap, expire;

  function automatic logic [8:0] preset(input logic [1:0] m);
    case (m)
      2'd1:    return 9'(T_STEP_SEC);
      2'd2:    return 9'(3 * T_STEP_SEC);
      2'd3:    return 9'(5 * T_STEP_SEC);
      default: return 9'd0;
    endcase
  endfunction

  assign tick_wrap = (remain_q != 9'd0) && (presc_q == PSW'(TICK_1S - 1));
  assign expire    = tick_wrap && (remain_q == 9'd1);

  // Priority: stop > expiry > speed > timer button; losers in a cycle are dropped.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    speed_d  = speed_q;
    mode_d   = mode_q;
    remain_d = remain_q;
    presc_d  = '0;
    if (remain_q != 9'd0) begin
      presc_d = tick_wrap ? '0 : presc_q + PSW'(1);
      if (tick_wrap) remain_d = remain_q - 9'd1;
    end

    if (i_btn_stop || expire) begin
      speed_d  = S_OFF;
      mode_d   = 2'd0;
      remain_d = 9'd0;
      presc_d  = '0;
    end else if (i_btn_speed) begin
      speed_d = speed_e'(speed_q + 2'd1);
      if (speed_q == S_HIGH) begin
        mode_d   = 2'd0;
        remain_d = 9'd0;
        presc_d  = '0;
      end
    end else if (i_btn_timer && speed_q != S_OFF) begin
      mode_d   = mode_q + 2'd1;
      remain_d = preset(mode_q + 2'd1);
      presc_d  = '0;
    end
  end

  always_comb begin
    case (speed_q)
      S_LOW:   duty_new = PCW'(PWM_PERIOD / 4);
      S_MID:   duty_new = PCW'(PWM_PERIOD / 2);
      S_HIGH:  duty_new = PCW'(3 * PWM_PERIOD / 4);
      default: duty_new = '0;
    endcase
  end

  // The period's first compare already sees the duty being latched at counter 0.
  assign duty_eff = (pwm_cnt_q == '0) ? duty_new : duty_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      speed_q   <= S_OFF;
      mode_q    <= 2'd0;
      remain_q  <= 9'd0;
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      pwm_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      speed_q   <= speed_d;
      mode_q    <= mode_d;
      remain_q  <= remain_d;
      presc_q   <= presc_d;
      pwm_cnt_q <= (pwm_cnt_q == PCW'(PWM_PERIOD - 1)) ? '0 : pwm_cnt_q + PCW'(1);
      duty_q    <= duty_eff;
      pwm_q     <= (pwm_cnt_q < duty_eff);
    end
  end

  assign o_speed      = speed_q;
  assign o_timer_mode = mode_q;
  assign o_remain_sec = remain_q;
  assign o_pwm        = pwm_q;
  assign o_running    = (speed_q != S_OFF);

endmodule

// File: doc/motor_timer_ctrl.md
MOTOR_TIMER_CTRL -- requirements
Module: motor_timer_ctrl

Interface
REQ-001 Parameter TICK_1S, default 100_000_000: clock cycles per one-second timer tick.
REQ-002 Parameter PWM_PERIOD, default 100: PWM period in clock cycles, multiple of 4, at least 4.
REQ-003 Parameter T_STEP_SEC, default 60: base timer step in seconds; the largest preset (5*T_STEP_SEC) SHALL fit in 9 bits.
REQ-004 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 i_reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 i_btn_speed  input  1  single-cycle pulse from the debounced speed button.
REQ-007 i_btn_timer  input  1  single-cycle pulse from the debounced timer button.
REQ-008 i_btn_stop  input  1  single-cycle pulse from the debounced stop button.
REQ-009 o_speed  output  2  current speed state: 0 OFF, 1 LOW, 2 MID, 3 HIGH.
REQ-010 o_timer_mode  output  2  timer preset: 0 none, 1 = 1*T_STEP_SEC, 2 = 3*T_STEP_SEC, 3 = 5*T_STEP_SEC.
REQ-011 o_remain_sec  output  9  seconds remaining on the active timer; 0 when no timer is active.
REQ-012 o_pwm  output  1  registered motor PWM drive.
REQ-013 o_running  output  1  high when o_speed != 0.

Function
REQ-014 Speed FSM states SHALL be OFF, LOW, MID and HIGH; each i_btn_speed pulse SHALL advance OFF->LOW->MID->HIGH->OFF, one step per pulse.
REQ-015 An i_btn_stop pulse SHALL force OFF from any state on the next edge.
REQ-016 Per-cycle event priority SHALL be: stop > timer expiry > speed > timer button; lower-priority events in the same cycle SHALL be ignored, not queued.
REQ-017 An i_btn_timer pulse in OFF SHALL be ignored.
REQ-018 In any other state, an i_btn_timer pulse SHALL advance o_timer_mode 0->1->2->3->0 and load o_remain_sec with the preset (0, T, 3T or 5T).
REQ-019 The same timer load SHALL clear the one-second prescaler to 0.
REQ-020 The prescaler SHALL count 0..TICK_1S-1 only while o_remain_sec != 0, and hold at 0 otherwise.
REQ-021 On each prescaler wrap, o_remain_sec SHALL decrement by 1.
REQ-022 Expiry: when o_remain_sec is 1 and the prescaler wraps, o_remain_sec, o_timer_mode and o_speed SHALL all become 0 on the same edge.
REQ-023 Any entry into OFF (stop, speed wrap or expiry) SHALL clear o_timer_mode, o_remain_sec and the prescaler.
REQ-024 A speed change between non-OFF states SHALL NOT alter the timer.
REQ-025 PWM counter SHALL count 0..PWM_PERIOD-1 continuously and wrap to 0.
REQ-026 Duty values SHALL be 0, PWM_PERIOD/4, PWM_PERIOD/2 and 3*PWM_PERIOD/4 for OFF, LOW, MID and HIGH respectively.
REQ-027 Duty SHALL be latched only when the PWM counter is 0, so a speed change takes effect at the next period boundary.
REQ-028 o_pwm SHALL be registered from (counter < latched duty), giving exactly one cycle of latency after the compare.
REQ-029 Once OFF is latched, o_pwm SHALL be constantly 0.
REQ-030 o_running SHALL be derived combinationally from o_speed.

Reset
REQ-031 While i_reset = 0, all of the following SHALL be 0, asynchronously: o_speed, o_timer_mode, o_remain_sec, o_pwm, prescaler, PWM counter and latched duty.
REQ-032 Reset assertion mid-countdown or mid-PWM-period SHALL abort immediately, with no pending button event retained.
REQ-033 After i_reset returns to 1, operation SHALL restart from OFF on the first clock edge.

Verification
(Bench parameters: TICK_1S = 10, PWM_PERIOD = 8, T_STEP_SEC = 2.)
REQ-034 Two i_btn_speed pulses from reset -> o_speed = 2; o_pwm high 4 of every 8 cycles once the next period starts.
REQ-035 Four speed pulses -> o_speed = 0, o_pwm = 0, o_running = 0.
REQ-036 From LOW, two i_btn_timer pulses -> o_timer_mode = 2, o_remain_sec = 6; it then decrements every 10 cycles, and 60 cycles after the load o_speed = 0 and o_remain_sec = 0.
REQ-037 i_btn_timer in OFF -> o_timer_mode stays 0; i_btn_stop and i_btn_speed in the same cycle while in MID -> OFF.
REQ-038 From HIGH with o_remain_sec = 1 and prescaler = 9, an i_btn_speed pulse -> expiry wins and o_speed = 0.
REQ-039 i_reset pulsed low mid-countdown in MID -> all outputs 0 immediately; a speed pulse after release -> o_speed = 1.
